ub_arbiter: RTL and testbench

Single-port unified-buffer (UB) arbiter and burst sequencer for the tiny TPU. It shares one synchronous SRAM port among four requesters: host load, weight fetch, input fetch, and accumulator store. The control unit and the loaders raise burst requests. The arbiter grants one requester at a time, round-robin, and issues one UB access per cycle for the whole burst.

---
 rtl/tpu_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/ub_arbiter.sv | 152 +++++++++++++++
 tb/tb_ub_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : tpu_pkg
// Brief    : Shared types and constants for the tiny TPU unified-buffer arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tpu_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned PORT_HOST     = 0;
  localparam int unsigned PORT_WEIGHT   = 1;
  localparam int unsigned PORT_INPUT    = 2;
  localparam int unsigned PORT_STORE    = 3;
  localparam int unsigned LEN_W_DEFAULT = 4;

  function automatic logic [3:0] port_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational 4-way round-robin picker; search starts after last_ptr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import tpu_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic       w_found;
  logic [1:0] w_cand;

  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    gnt_idx = '0;
    // i = 4 wraps back onto last_ptr itself, so it is considered last
    for (int i = 1; i <= 4; i++) begin
      w_cand = last_ptr + 2'(i);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        gnt_idx = w_cand;
      end
    end
    gnt = w_found ? port_onehot(gnt_idx) : 4'b0000;
  end

endmodule

`default_nettype wire

// File: rtl/ub_arbiter.sv
//------------------------------------------------------------------------------
// Module   : ub_arbiter
// Brief    : Unified-buffer arbiter and burst sequencer, four requesters, one
//            SRAM port. Optional macro UB_ARB_STORE_PRIO_EN gives port 3 priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ub_arbiter
  import tpu_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [3:0]          req_we,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*LEN_W-1:0]  req_len,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic [3:0]          gnt,
  output logic [3:0]          beat,
  output logic [3:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [3:0]          done,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [LEN_W:0] c_one        = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] c_full_burst = {1'b1, {LEN_W{1'b0}}};

  arb_state_t        r_state, w_state_nxt;
  logic [1:0]        r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W:0]    r_nbeats;
  logic [LEN_W:0]    r_cnt;
  logic [1:0]        r_last_ptr;
  logic [3:0]        r_done;
  logic [3:0]        r_rvalid;

  logic [3:0]        w_masked, w_rr_req, w_rr_gnt;
  logic [1:0]        w_rr_idx, w_win_idx;
  logic              w_win_valid, w_upd_ptr;
  logic [LEN_W-1:0]  w_len_raw;
  logic [LEN_W:0]    w_nbeats_new;
  logic              w_last, w_load, w_finish;

  // The port finishing this cycle is hidden so a late req drop is not re-granted
  assign w_masked = req & ~r_done;

`ifdef UB_ARB_STORE_PRIO_EN
  assign w_rr_req    = {1'b0, w_masked[2:0]};
  assign w_win_valid = w_masked[3] | (|w_rr_gnt);
  assign w_win_idx   = w_masked[3] ? 2'(PORT_STORE) : w_rr_idx;
  assign w_upd_ptr   = ~w_masked[3];
`else
  assign w_rr_req    = w_masked;
  assign w_win_valid = |w_rr_gnt;
  assign w_win_idx   = w_rr_idx;
  assign w_upd_ptr   = 1'b1;
`endif

  rr_arbiter u_rr (
    .req      (w_rr_req),
    .last_ptr (r_last_ptr),
    .gnt      (w_rr_gnt),
    .gnt_idx  (w_rr_idx)
  );

  assign w_len_raw    = req_len[w_win_idx*LEN_W +: LEN_W];
  assign w_nbeats_new = (w_len_raw == '0) ? c_full_burst : {1'b0, w_len_raw};
  assign w_last       = (r_cnt == (r_nbeats - c_one));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    gnt         = '0;
    beat        = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_load      = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        gnt       = port_onehot(r_owner);
        beat      = port_onehot(r_owner);
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_base + ADDR_W'(r_cnt);
        mem_wdata = req_wdata[r_owner*DATA_W +: DATA_W];
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= '0;
      r_we       <= 1'b0;
      r_base     <= '0;
      r_nbeats   <= '0;
      r_cnt      <= '0;
      r_last_ptr <= 2'(PORT_STORE);
      r_done     <= '0;
      r_rvalid   <= '0;
    end else begin
      r_done   <= w_finish ? port_onehot(r_owner) : 4'b0000;
      r_rvalid <= (r_state == BURST && !r_we) ? port_onehot(r_owner) : 4'b0000;
      if (w_load) begin
        r_owner  <= w_win_idx;
        r_we     <= req_we[w_win_idx];
        r_base   <= req_addr[w_win_idx*ADDR_W +: ADDR_W];
        r_nbeats <= w_nbeats_new;
        r_cnt    <= '0;
        if (w_upd_ptr) r_last_ptr <= w_win_idx;
      end else if (r_state == BURST) begin
        r_cnt <= r_cnt + c_one;
      end
    end
  end

  // SRAM data arrives one cycle after the beat, aligned with the registered rvalid
  assign rvalid = r_rvalid;
  assign rdata  = (|r_rvalid) ? mem_rdata : '0;
  assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ub_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_ub_arbiter
// Brief    : Self-checking bench for ub_arbiter with an SRAM model and a
//            transaction-level reference of grants, beats and UB contents.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ub_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req, req_we;
  logic [4*AW-1:0] req_addr;
  logic [4*LW-1:0] req_len;
  logic [4*DW-1:0] req_wdata;
  logic [3:0]    gnt, beat, rvalid, done;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ub_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .beat(beat),
    .rvalid(rvalid), .rdata(rdata), .done(done), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM seen by the DUT, and the bench's own expectation of its contents
  logic [DW-1:0] ub      [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ub[mem_addr] <= mem_wdata;
      else        mem_rdata    <= ub[mem_addr];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int tb_last = 3;
  logic [AW-1:0] m_addr [4];
  int            m_len  [4];
  logic          m_we   [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int p, input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req[p]             = 1'b1;
    req_we[p]          = we;
    req_addr[p*AW +: AW] = a;
    req_len[p*LW +: LW]  = l;
    m_we[p]   = we;
    m_addr[p] = a;
    m_len[p]  = (l == 0) ? (1 << LW) : int'(l);
  endtask

  function automatic int pick();
`ifdef UB_ARB_STORE_PRIO_EN
    if (req[3]) return 3;
`endif
    for (int i = 1; i <= 4; i++) begin
      if (req[(tb_last + i) % 4]) return (tb_last + i) % 4;
    end
    return -1;
  endfunction

  // Entered at a negedge of an IDLE cycle in which port p is the expected winner
  task automatic serve(input int p);
    int            n;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    logic [3:0]    oh;
    n  = m_len[p];
    oh = 4'b0001 << p;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      w = DW'($urandom);
      if (m_we[p]) req_wdata[p*DW +: DW] = w;
      @(negedge clk);
      a = m_addr[p] + AW'(k);
      chk($sformatf("gnt p%0d k%0d", p, k), 32'(gnt), 32'(oh));
      chk($sformatf("beat p%0d k%0d", p, k), 32'(beat), 32'(oh));
      chk($sformatf("mem_en p%0d k%0d", p, k), 32'(mem_en), 32'd1);
      chk($sformatf("mem_we p%0d k%0d", p, k), 32'(mem_we), 32'(m_we[p]));
      chk($sformatf("mem_addr p%0d k%0d", p, k), 32'(mem_addr), 32'(a));
      chk($sformatf("done_mid p%0d k%0d", p, k), 32'(done), 32'd0);
      if (m_we[p]) begin
        chk($sformatf("mem_wdata p%0d k%0d", p, k), 32'(mem_wdata), 32'(w));
        ref_mem[a] = w;
      end
      chk($sformatf("rvalid p%0d k%0d", p, k), 32'(rvalid), (k > 0 && !m_we[p]) ? 32'(oh) : 32'd0);
      if (k > 0 && !m_we[p])
        chk($sformatf("rdata p%0d k%0d", p, k), 32'(rdata), 32'(ref_mem[m_addr[p] + AW'(k-1)]));
      if (k == 0) begin
        // drop the request and disturb the latched fields mid-burst
        req[p] = 1'b0;
        req_addr[p*AW +: AW] = AW'($urandom);
        req_len[p*LW +: LW]  = LW'($urandom);
      end
    end
    @(negedge clk);
    chk($sformatf("done p%0d", p), 32'(done), 32'(oh));
    chk($sformatf("gnt_end p%0d", p), 32'(gnt), 32'd0);
    chk($sformatf("mem_en_end p%0d", p), 32'(mem_en), 32'd0);
    chk($sformatf("rvalid_end p%0d", p), 32'(rvalid), m_we[p] ? 32'd0 : 32'(oh));
    if (!m_we[p])
      chk($sformatf("rdata_end p%0d", p), 32'(rdata), 32'(ref_mem[m_addr[p] + AW'(n-1)]));
  endtask

  task automatic run_pending();
    int p;
    while (req != 4'b0000) begin
      p = pick();
      if (p < 0) break;
`ifdef UB_ARB_STORE_PRIO_EN
      if (p != 3) tb_last = p;
`else
      tb_last = p;
`endif
      serve(p);
    end
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset   = 1'b0;
    tb_last = 3;
  endtask

  initial begin
    req = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ub[i]      = DW'(i * 7) ^ 16'h5a5a;
      ref_mem[i] = DW'(i * 7) ^ 16'h5a5a;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_beat", 32'(beat), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // simultaneous requests straight out of reset
    for (int p = 0; p < 4; p++) post(p, p[0], AW'(13'h100 + p * 16), 4'd1);
    run_pending();

    post(1, 1'b0, 13'h010, 4'd3);
    run_pending();

    post(0, 1'b1, 13'h1FFE, 4'd4);
    run_pending();
    post(3, 1'b0, 13'h1FFE, 4'd4);
    run_pending();

    post(2, 1'b0, AW'($urandom), 4'd0);
    run_pending();

    pulse_reset();
    post(0, 1'b0, 13'h0200, 4'd2);
    post(3, 1'b1, 13'h0300, 4'd2);
    run_pending();

    repeat (25) begin
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 1) == 1)
          post(p, 1'($urandom), AW'($urandom), LW'($urandom_range(0, 6)));
      if (req == 4'b0000) post($urandom_range(0, 3), 1'($urandom), AW'($urandom), 4'd2);
      run_pending();
    end

    // reset in the middle of a 5-beat read
    post(1, 1'b0, 13'h0440, 4'd5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == 0) req[1] = 1'b0;
    end
    chk("mid_mem_addr", 32'(mem_addr), 32'h0442);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_beat", 32'(beat), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    chk("mid_rst_done", 32'(done), 32'd0);
    reset   = 1'b0;
    tb_last = 3;
    post(2, 1'b0, 13'h0777, 4'd2);
    run_pending();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
